sync_down_counter_jk: RTL and testbench

//   Loadable synchronous down-counter / interval timer.

---
 rtl/sync_down_counter_jk.sv | 97 +++++++++
 tb/tb_sync_down_counter_jk.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter_jk.sv
// Loadable synchronous down-counter / interval timer built from JK stages in toggle mode.
// Counts a preset down to zero, pulses tc for one cycle, then stops or auto-reloads.
module sync_down_counter_jk #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             dec_en;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_dec;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Each JK stage has J=K=t[i]; a bit toggles only when all lower bits are 0.
  always_comb begin
    dec_en = (state_q == RUN) && count_enable && (q_q != '0);
    t      = '0;
    t[0]   = dec_en;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & ~q_q[i-1];
    end
    q_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      q_dec[i] = (t[i] & ~q_q[i]) | (~t[i] & q_q[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          if (count_enable) begin
            if (q_q == '0) begin
              // Only reachable after an auto-reload wrap to zero.
              q_d = reload_q;
            end else begin
              q_d = q_dec;
              if (q_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (!auto_reload) state_d = DONE;
              end
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_sync_down_counter_jk.sv
// Directed, scoreboard-based bench for sync_down_counter_jk (WIDTH=4).
module tb_sync_down_counter_jk;

  localparam int WIDTH = 4;

  logic             clk;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             count_enable;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             busy;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             busy;
  } exp_t;

  exp_t scoreboard[$];
  int   compared;
  int   mismatched;

  sync_down_counter_jk #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .clear        (clear),
    .load         (load),
    .load_value   (load_value),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .q            (q),
    .zero         (zero),
    .tc           (tc),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entry");
      return;
    end
    e = scoreboard.pop_front();
    compared++;
    assert (q === e.q) else begin
      mismatched++;
      $error("[TB] FAIL %s.q observed=%0d expected=%0d", e.tag, q, e.q);
    end
    compared++;
    assert (zero === e.zero) else begin
      mismatched++;
      $error("[TB] FAIL %s.zero observed=%0b expected=%0b", e.tag, zero, e.zero);
    end
    compared++;
    assert (tc === e.tc) else begin
      mismatched++;
      $error("[TB] FAIL %s.tc observed=%0b expected=%0b", e.tag, tc, e.tc);
    end
    compared++;
    assert (busy === e.busy) else begin
      mismatched++;
      $error("[TB] FAIL %s.busy observed=%0b expected=%0b", e.tag, busy, e.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check after the edge.
  task automatic applyStimulus(input string tag, input logic clr, input logic ld,
                               input logic [WIDTH-1:0] lv, input logic en, input logic ar,
                               input logic [WIDTH-1:0] exp_q, input logic exp_tc,
                               input logic exp_busy);
    exp_t e;
    clear        = clr;
    load         = ld;
    load_value   = lv;
    count_enable = en;
    auto_reload  = ar;
    e.tag  = tag;
    e.q    = exp_q;
    e.zero = (exp_q == '0);
    e.tc   = exp_tc;
    e.busy = exp_busy;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    clear        = 1'b0;
    load         = 1'b0;
    load_value   = '0;
    count_enable = 1'b0;
    auto_reload  = 1'b0;
    #2;

    for (int i = 0; i < 2; i++) begin
      applyStimulus("reset", 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 4'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus("idle_en", 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end

    applyStimulus("oneshot_load", 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    for (int v = 4; v >= 1; v--) begin
      applyStimulus("oneshot_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'(v), 1'b0, 1'b1);
    end
    applyStimulus("oneshot_tc", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("done_hold", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end

    applyStimulus("ar_load", 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
    for (int p = 0; p < 2; p++) begin
      applyStimulus("ar_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
      applyStimulus("ar_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
      applyStimulus("ar_tc", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
      applyStimulus("ar_reload", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
    end

    applyStimulus("gap_load", 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("gap_hold", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1);
    end
    applyStimulus("gap_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    applyStimulus("gap_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    applyStimulus("reload_at4", 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1);
    for (int v = 8; v >= 1; v--) begin
      applyStimulus("cnt9", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'(v), 1'b0, 1'b1);
    end
    applyStimulus("load_at1", 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    applyStimulus("cnt2", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    applyStimulus("cnt2_tc", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

    applyStimulus("clr_load", 1'b1, 1'b1, 4'd15, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1);
    for (int v = 14; v >= 7; v--) begin
      applyStimulus("clr_cnt", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'(v), 1'b0, 1'b1);
    end
    applyStimulus("clr_mid", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus("clr_idle", 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    end

    applyStimulus("load0", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus("load0_hold", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus("load15", 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1);
    for (int v = 14; v >= 0; v--) begin
      applyStimulus("cnt15", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'(v), 1'(v == 0), 1'(v != 0));
    end

    if (scoreboard.size() != 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", scoreboard.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
